// File: rtl/stack_ctrl.sv
// LIFO stack controller: push/pop/peek/flush requests are served one at a time
// through an IDLE -> (READ) -> RESP sequence with sticky overflow/underflow flags.
module stack_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_data,
  output logic             req_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [DEPTH:0]   count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf,
  input  logic             err_clr,
  output logic [1:0]       dbg_state
);

  localparam int ENTRIES = 1 << DEPTH;
  localparam logic [DEPTH:0] CNT_MAX = (DEPTH+1)'(ENTRIES);

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q;
  logic [DEPTH:0]     count_q;
  logic [DEPTH-1:0]   rd_ptr_q;
  logic               rsp_valid_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic               rsp_err_q;
  logic               ovf_q;
  logic               unf_q;
  logic [WIDTH-1:0]   mem_q [ENTRIES];

  logic accept;
  logic wr_en;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so at most one request is in flight.
  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign full      = (count_q == CNT_MAX);
  assign empty     = (count_q == '0);
  assign wr_en     = accept && (req_op == OP_PUSH) && !full;

  assign count     = count_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign dbg_state = state_q;

  // Storage has no reset; entries are only observable after being written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[count_q[DEPTH-1:0]] <= req_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      // Clear first so that an error event later in this block wins.
      if (err_clr) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            case (req_op)
              OP_PUSH: begin
                if (full) begin
                  ovf_q     <= 1'b1;
                  rsp_err_q <= 1'b1;
                end else begin
                  count_q <= count_q + (DEPTH+1)'(1);
                end
                rsp_valid_q <= 1'b1;
                state_q     <= RESP;
              end
              OP_POP, OP_PEEK: begin
                if (empty) begin
                  unf_q       <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
                end else begin
                  rd_ptr_q <= count_q[DEPTH-1:0] - DEPTH'(1);
                  if (req_op == OP_POP) count_q <= count_q - (DEPTH+1)'(1);
                  state_q  <= READ;
                end
              end
              default: begin
                count_q     <= '0;
                rsp_valid_q <= 1'b1;
                state_q     <= RESP;
              end
            endcase
          end
        end
        READ: begin
          rsp_data_q  <= mem_q[rd_ptr_q];
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_data_q  <= '0;
          rsp_err_q   <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          rsp_valid_q <= 1'b0;
          rsp_data_q  <= '0;
          rsp_err_q   <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl: fill/drain ordering, overflow, underflow,
// peek/flush, back-to-back requests and reset abort.
module tb_stack_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        ovf;
  logic        unf;
  logic        err_clr;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  stack_ctrl #(.WIDTH(32), .DEPTH(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .count(count), .full(full), .empty(empty), .ovf(ovf), .unf(unf),
    .err_clr(err_clr), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where rsp_valid was seen.
  task automatic do_req(input logic [1:0] op, input logic [31:0] d, input logic clr,
                        output logic [31:0] rd, output logic re, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_op = op; req_data = d; err_clr = clr;
    @(posedge clk);
    #1;
    req_valid = 1'b0; err_clr = 1'b0;
    lat = 0; rd = '0; re = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i; rd = rsp_data; re = rsp_err;
        break;
      end
    end
    if (lat == 0) check("rsp_timeout", 64'(lat), 64'd1);
  endtask

  task automatic push_chk(input string tag, input logic [31:0] d, input logic exp_err);
    logic [31:0] rd; logic re; int lat;
    do_req(2'b00, d, 1'b0, rd, re, lat);
    check({tag, "_err"}, 64'(re), 64'(exp_err));
    check({tag, "_lat"}, 64'(lat), 64'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] op, input logic [31:0] exp_d,
                        input logic exp_err, input int exp_lat);
    logic [31:0] rd; logic re; int lat;
    do_req(op, 32'h0, 1'b0, rd, re, lat);
    check({tag, "_data"}, 64'(rd), 64'(exp_d));
    check({tag, "_err"}, 64'(re), 64'(exp_err));
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd; logic re; int lat;
    int acc_n, rsp_n;
    logic push_next;
    logic [31:0] last_push;

    reset = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_data = '0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_flags", {62'd0, ovf, unf}, 64'd0);
    check("rst_rsp", {31'd0, rsp_err, rsp_data}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Fill then drain in LIFO order
    for (int i = 0; i < 8; i++) push_chk("fill", 32'hA0 + 32'(i), 1'b0);
    check("fill_full", 64'(full), 64'd1);
    check("fill_count", 64'(count), 64'd8);
    for (int i = 0; i < 8; i++) rd_chk("drain", 2'b01, 32'hA7 - 32'(i), 1'b0, 2);
    check("drain_empty", 64'(empty), 64'd1);

    // Overflow: rejected push leaves content intact
    for (int i = 0; i < 8; i++) push_chk("refill", 32'hA0 + 32'(i), 1'b0);
    do_req(2'b00, 32'hDEAD, 1'b0, rd, re, lat);
    check("ovf_err", 64'(re), 64'd1);
    check("ovf_data", 64'(rd), 64'd0);
    check("ovf_flag", 64'(ovf), 64'd1);
    check("ovf_count", 64'(count), 64'd8);
    rd_chk("ovf_pop", 2'b01, 32'hA7, 1'b0, 2);
    check("ovf_sticky", 64'(ovf), 64'd1);
    rd_chk("flush_full", 2'b11, 32'h0, 1'b0, 1);
    check("flush_full_cnt", 64'(count), 64'd0);
    clr_pulse();
    check("ovf_clr", 64'(ovf), 64'd0);

    // Underflow
    rd_chk("unf_pop", 2'b01, 32'h0, 1'b1, 1);
    check("unf_flag", 64'(unf), 64'd1);
    rd_chk("unf_peek", 2'b10, 32'h0, 1'b1, 1);
    check("unf_count", 64'(count), 64'd0);
    clr_pulse();
    check("unf_clr", 64'(unf), 64'd0);
    do_req(2'b01, 32'h0, 1'b1, rd, re, lat);
    check("unf_setwins", 64'(unf), 64'd1);
    clr_pulse();

    // Peek twice then flush
    push_chk("p11", 32'h11, 1'b0);
    rd_chk("peek1", 2'b10, 32'h11, 1'b0, 2);
    rd_chk("peek2", 2'b10, 32'h11, 1'b0, 2);
    check("peek_count", 64'(count), 64'd1);
    rd_chk("flush", 2'b11, 32'h0, 1'b0, 1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_empty", 64'(empty), 64'd1);
    @(negedge clk);
    check("rsp_one_cycle", {32'd0, rsp_valid, rsp_data[30:0]}, 64'd0);

    // req_valid held high with alternating push/pop for 20 cycles
    acc_n = 0; rsp_n = 0; push_next = 1'b1; last_push = '0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) begin
        rsp_n++;
        if (exp_q.size() > 0) check("b2b_data", 64'(rsp_data), 64'(exp_q.pop_front()));
        else check("b2b_extra_rsp", 64'(rsp_n), 64'(acc_n));
      end
      if (req_ready) begin
        acc_n++;
        if (push_next) begin
          last_push = 32'h100 + 32'(c);
          req_op = 2'b00; req_data = last_push; exp_q.push_back(32'h0);
        end else begin
          req_op = 2'b01; req_data = 32'hBAD; exp_q.push_back(last_push);
        end
        push_next = !push_next;
      end else begin
        req_op = 2'b11; req_data = 32'hBAD;
      end
      req_valid = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (3) begin
      if (rsp_valid) begin
        rsp_n++;
        if (exp_q.size() > 0) check("b2b_data", 64'(rsp_data), 64'(exp_q.pop_front()));
        else check("b2b_extra_rsp", 64'(rsp_n), 64'(acc_n));
      end
      @(negedge clk);
    end
    check("b2b_accepts", 64'(acc_n), 64'd8);
    check("b2b_rsps", 64'(rsp_n), 64'd8);
    check("b2b_count", 64'(count), 64'd0);

    // Reset during READ of a pop aborts without response
    push_chk("p55", 32'h55, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("abort_in_read", 64'(dbg_state), 64'd1);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_rsp", 64'(rsp_valid), 64'd0);
    check("abort_count", 64'(count), 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready", 64'(req_ready), 64'd1);
    rsp_n = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) rsp_n++;
    end
    check("abort_no_rsp", 64'(rsp_n), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
